// File: rtl/vga_pkg.sv
// ---------------------------------------------------------------------------
// vga_pkg
// Shared constants and helpers for the 640x480 VGA framebuffer path.
// The framebuffer is 160x120 pixels, each shown as a 4x4 block on screen.
// A pixel address is {row[6:0], col[7:0]}.
// ---------------------------------------------------------------------------
package vga_pkg;

  localparam int H_ACTIVE       = 640;
  localparam int V_ACTIVE       = 480;
  localparam int FB_SCALE_SHIFT = 2;
  localparam int PIX_W          = 9;
  localparam int ADDR_W         = 15;
  localparam int FB_ROW_W       = 7;
  localparam int FB_COL_W       = 8;

  // Packs a framebuffer row/column pair into a RAM address.
  function automatic logic [ADDR_W-1:0] fb_addr(input logic [FB_ROW_W-1:0] row,
                                                input logic [FB_COL_W-1:0] col);
    return {row, col};
  endfunction

endpackage

// File: rtl/vga_fb_arbiter_if.sv
// ---------------------------------------------------------------------------
// vga_fb_arbiter_if
// Host read/write port of the framebuffer arbiter.
//   master : the host (drives request fields, receives READY/RVALID/RDATA)
//   slave  : the arbiter
// Signals:
//   HOST_VALID  request present        HOST_READY  request accepted this cycle
//   HOST_WE     1 = write, 0 = read    HOST_ADDR   framebuffer address
//   HOST_WDATA  write data             HOST_RVALID read data valid
//   HOST_RDATA  read data
// ---------------------------------------------------------------------------
interface vga_fb_arbiter_if #(
  parameter int PIX_W  = 9,
  parameter int ADDR_W = 15
);

  logic              HOST_VALID;
  logic              HOST_READY;
  logic              HOST_WE;
  logic [ADDR_W-1:0] HOST_ADDR;
  logic [PIX_W-1:0]  HOST_WDATA;
  logic              HOST_RVALID;
  logic [PIX_W-1:0]  HOST_RDATA;

  modport master (
    output HOST_VALID, HOST_WE, HOST_ADDR, HOST_WDATA,
    input  HOST_READY, HOST_RVALID, HOST_RDATA
  );

  modport slave (
    input  HOST_VALID, HOST_WE, HOST_ADDR, HOST_WDATA,
    output HOST_READY, HOST_RVALID, HOST_RDATA
  );

endinterface

// File: rtl/vga_sync_delay.sv
// ---------------------------------------------------------------------------
// vga_sync_delay
// N-stage shift register used to delay-match timing flags to the colour path.
// Ports:
//   i_clk   clock
//   i_rst   synchronous active-high reset, loads RST_VAL into every stage
//   i_d     W-bit input
//   o_q     W-bit output, i_d delayed by N cycles
// ---------------------------------------------------------------------------
module vga_sync_delay #(
  parameter int             N       = 2,
  parameter int             W       = 3,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_pipe [N];

  // Shift the flags one stage per clock; reset puts every stage in its inactive value.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < N; i++) begin
        r_pipe[i] <= RST_VAL;
      end
    end else begin
      r_pipe[0] <= i_d;
      for (int i = 1; i < N; i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end
    end
  end

  assign o_q = r_pipe[N-1];

endmodule

// File: rtl/vga_fb_arbiter.sv
// ---------------------------------------------------------------------------
// vga_fb_arbiter
// Shares one single-port video RAM between VGA scanout and a host port, and
// turns 160x120 framebuffer pixels into registered VGA colour + syncs.
// Scanout owns the RAM when DISPLAY_ON=1 and HPOS[1:0]=0; the host owns it in
// every other cycle.
// Ports:
//   CLK_IN, RST              pixel clock, synchronous active-high reset
//   HPOS, VPOS, DISPLAY_ON   raster position and active-video flag
//   HSYNC_IN, VSYNC_IN       active-high syncs from the timing generator
//   host                     host request/response port (slave side)
//   MEM_ADDR/WE/WDATA        RAM command, combinational
//   MEM_RDATA                RAM read data, one cycle after the address
//   VGA_RED/GREEN/BLUE       registered 3-bit colour
//   VGA_HSYNC, VGA_VSYNC     active-low syncs, delay-matched to colour
// ---------------------------------------------------------------------------
module vga_fb_arbiter #(
  parameter int PIX_W  = 9,
  parameter int ADDR_W = 15
) (
  input  logic              CLK_IN,
  input  logic              RST,
  input  logic [9:0]        HPOS,
  input  logic [9:0]        VPOS,
  input  logic              DISPLAY_ON,
  input  logic              HSYNC_IN,
  input  logic              VSYNC_IN,
  vga_fb_arbiter_if.slave   host,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic              MEM_WE,
  output logic [PIX_W-1:0]  MEM_WDATA,
  input  logic [PIX_W-1:0]  MEM_RDATA,
  output logic [2:0]        VGA_RED,
  output logic [2:0]        VGA_GREEN,
  output logic [2:0]        VGA_BLUE,
  output logic              VGA_HSYNC,
  output logic              VGA_VSYNC
);

  import vga_pkg::*;

  logic [FB_ROW_W-1:0] w_row;
  logic [FB_COL_W-1:0] w_col;
  logic                w_scan_slot;
  logic                w_host_acc;
  logic                w_rd_acc;
  logic [PIX_W-1:0]    w_pix;
  logic [1:0]          w_sync_q;
  logic                w_de_d1;

  logic                r_scan_d1;
  logic                r_rd_pend;
  logic [PIX_W-1:0]    r_pix;
  logic [2:0]          r_red;
  logic [2:0]          r_green;
  logic [2:0]          r_blue;

  // Slot decision, RAM command mux and host response.
  always_comb begin
    w_row       = FB_ROW_W'(VPOS >> FB_SCALE_SHIFT);
    w_col       = FB_COL_W'(HPOS >> FB_SCALE_SHIFT);
    w_scan_slot = DISPLAY_ON & (HPOS[FB_SCALE_SHIFT-1:0] == '0);

    // READY does not wait for VALID: a host slot is offered whether used or not.
    host.HOST_READY = ~RST & ~w_scan_slot;
    w_host_acc      = host.HOST_READY & host.HOST_VALID;
    w_rd_acc        = w_host_acc & ~host.HOST_WE;

    if (w_scan_slot) begin
      MEM_ADDR = ADDR_W'(fb_addr(w_row, w_col));
    end else begin
      MEM_ADDR = host.HOST_ADDR;
    end
    MEM_WE    = w_host_acc & host.HOST_WE;
    MEM_WDATA = host.HOST_WDATA;

    // Gating with RST discards a read accepted just before reset was asserted.
    host.HOST_RVALID = r_rd_pend & ~RST;
    if (host.HOST_RVALID) begin
      host.HOST_RDATA = MEM_RDATA;
    end else begin
      host.HOST_RDATA = '0;
    end

    // The first pixel of a group is taken straight off the RAM so it reaches
    // the colour register in the same cycle it is captured.
    if (r_scan_d1) begin
      w_pix = MEM_RDATA;
    end else begin
      w_pix = r_pix;
    end
  end

  // Scan capture, read tracking and the registered colour stage.
  always_ff @(posedge CLK_IN) begin
    if (RST) begin
      r_scan_d1 <= 1'b0;
      r_rd_pend <= 1'b0;
      r_pix     <= '0;
      r_red     <= 3'd0;
      r_green   <= 3'd0;
      r_blue    <= 3'd0;
    end else begin
      r_scan_d1 <= w_scan_slot;
      r_rd_pend <= w_rd_acc;
      if (r_scan_d1) begin
        r_pix <= MEM_RDATA;
      end
      if (w_de_d1) begin
        r_red   <= w_pix[8:6];
        r_green <= w_pix[5:3];
        r_blue  <= w_pix[2:0];
      end else begin
        r_red   <= 3'd0;
        r_green <= 3'd0;
        r_blue  <= 3'd0;
      end
    end
  end

  // Syncs are inverted before the pipe so the stages hold the active-low
  // form and reset to the inactive (high) level.
  vga_sync_delay #(
    .N       (2),
    .W       (2),
    .RST_VAL (2'b11)
  ) u_sync_dly (
    .i_clk (CLK_IN),
    .i_rst (RST),
    .i_d   ({~HSYNC_IN, ~VSYNC_IN}),
    .o_q   (w_sync_q)
  );

  // DISPLAY_ON needs one stage here: the colour register is its second stage.
  vga_sync_delay #(
    .N       (1),
    .W       (1),
    .RST_VAL (1'b0)
  ) u_de_dly (
    .i_clk (CLK_IN),
    .i_rst (RST),
    .i_d   (DISPLAY_ON),
    .o_q   (w_de_d1)
  );

  assign VGA_RED   = r_red;
  assign VGA_GREEN = r_green;
  assign VGA_BLUE  = r_blue;
  assign VGA_HSYNC = w_sync_q[1];
  assign VGA_VSYNC = w_sync_q[0];

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_vga_fb_arbiter
// Directed bench for vga_fb_arbiter with a one-cycle-latency RAM, a
// framebuffer-level reference model checked every cycle, and literal checks
// for reset, blanking write, scan fetch, contention, host read and reset
// during a read.
// ---------------------------------------------------------------------------
module tb_vga_fb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  hpos, vpos;
  logic        de, hs, vs;
  logic [14:0] mem_addr;
  logic        mem_we;
  logic [8:0]  mem_wdata;
  logic [8:0]  mem_rdata;
  logic [2:0]  red, green, blue;
  logic        vga_hs, vga_vs;

  int checks   = 0;
  int failures = 0;

  always #20 clk = ~clk;

  vga_fb_arbiter_if #(.PIX_W(9), .ADDR_W(15)) u_if ();

  vga_fb_arbiter #(.PIX_W(9), .ADDR_W(15)) dut (
    .CLK_IN     (clk),
    .RST        (rst),
    .HPOS       (hpos),
    .VPOS       (vpos),
    .DISPLAY_ON (de),
    .HSYNC_IN   (hs),
    .VSYNC_IN   (vs),
    .host       (u_if),
    .MEM_ADDR   (mem_addr),
    .MEM_WE     (mem_we),
    .MEM_WDATA  (mem_wdata),
    .MEM_RDATA  (mem_rdata),
    .VGA_RED    (red),
    .VGA_GREEN  (green),
    .VGA_BLUE   (blue),
    .VGA_HSYNC  (vga_hs),
    .VGA_VSYNC  (vga_vs)
  );

  // Single-port RAM with one-cycle read latency.
  logic [8:0] ram [0:32767] = '{default: 9'h000};
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic       rst;
    logic       de;
    logic       hs;
    logic       vs;
    logic [8:0] pix;
  } hist_t;

  logic [8:0] fb [0:32767] = '{default: 9'h000};
  hist_t      h1 = '{1'b1, 1'b0, 1'b0, 1'b0, 9'h000};
  hist_t      h2 = '{1'b1, 1'b0, 1'b0, 1'b0, 9'h000};
  logic [8:0] grp_pix = 9'h000;
  logic       rd_pend = 1'b0;
  logic [8:0] rd_val  = 9'h000;

  always @(negedge clk) begin : cmp
    logic        scan_e, ready_e, wr_e;
    logic [8:0]  col_e;
    int          scan_a;
    scan_e  = de && (hpos % 4 == 0);
    ready_e = !rst && !scan_e;
    wr_e    = ready_e && u_if.HOST_VALID && u_if.HOST_WE;
    scan_a  = ((vpos / 4) % 128) * 256 + (hpos / 4);

    chk("ready", u_if.HOST_READY, ready_e);
    if (!rst) begin
      if (scan_e) chk("scan_addr", mem_addr, scan_a);
      else        chk("host_addr", mem_addr, u_if.HOST_ADDR);
    end
    chk("mem_we", mem_we, wr_e);
    if (wr_e) chk("mem_wdata", mem_wdata, u_if.HOST_WDATA);
    chk("rvalid", u_if.HOST_RVALID, rd_pend && !rst);
    if (rd_pend && !rst) chk("rdata", u_if.HOST_RDATA, rd_val);

    col_e = (!h1.rst && !h2.rst && h2.de) ? h2.pix : 9'h000;
    chk("rgb", {red, green, blue}, col_e);
    chk("hsync", vga_hs, (h1.rst || h2.rst) ? 1'b1 : !h2.hs);
    chk("vsync", vga_vs, (h1.rst || h2.rst) ? 1'b1 : !h2.vs);

    // advance model state with this cycle's events
    if (wr_e) fb[u_if.HOST_ADDR] = u_if.HOST_WDATA;
    rd_pend = ready_e && u_if.HOST_VALID && !u_if.HOST_WE;
    if (rd_pend) rd_val = fb[u_if.HOST_ADDR];
    if (rst)         grp_pix = 9'h000;
    else if (scan_e) grp_pix = fb[scan_a];
    h2 = h1;
    h1 = '{rst, de, hs, vs, grp_pix};
  end

  // ---------------- stimulus ----------------
  task automatic set_pos(input int h, input int v);
    hpos = 10'(h);
    vpos = 10'(v);
    de   = (h < 640) && (v < 480);
    hs   = (h >= 656) && (h < 752);
    vs   = (v >= 490) && (v < 492);
  endtask

  task automatic host_drv(input logic valid, input logic we, input int addr, input int wd);
    u_if.HOST_VALID = valid;
    u_if.HOST_WE    = we;
    u_if.HOST_ADDR  = 15'(addr);
    u_if.HOST_WDATA = 9'(wd);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int acc, stall;
    rst = 1'b1;
    set_pos(100, 10);
    host_drv(1'b1, 1'b1, 5, 9'h1FF);

    // reset held three cycles mid-line
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin
        next_cycle();
        set_pos(100 + i, 10);
      end
      @(negedge clk);
      chk("rst_rgb", {red, green, blue}, 9'h000);
      chk("rst_hsync", vga_hs, 1'b1);
      chk("rst_vsync", vga_vs, 1'b1);
      chk("rst_ready", u_if.HOST_READY, 1'b0);
      chk("rst_mem_we", mem_we, 1'b0);
    end

    next_cycle(); rst = 1'b0; set_pos(0, 500); host_drv(1'b0, 1'b0, 0, 0);

    // blanking write
    next_cycle(); set_pos(10, 500); host_drv(1'b1, 1'b1, 5, 9'h1FF);
    @(negedge clk);
    chk("blank_ready", u_if.HOST_READY, 1'b1);
    chk("blank_we", mem_we, 1'b1);
    chk("blank_addr", mem_addr, 15'h0005);
    chk("blank_wdata", mem_wdata, 9'h1FF);

    next_cycle(); set_pos(11, 500); host_drv(1'b1, 1'b1, 1, 9'h1C0);
    next_cycle(); set_pos(12, 500); host_drv(1'b1, 1'b1, 15'h0123, 9'h0AB);
    next_cycle(); set_pos(13, 500); host_drv(1'b1, 1'b0, 15'h0123, 0);
    @(negedge clk);
    chk("rd_accept", u_if.HOST_READY, 1'b1);
    next_cycle(); set_pos(14, 500); host_drv(1'b0, 1'b0, 0, 0);
    @(negedge clk);
    chk("rd_rvalid", u_if.HOST_RVALID, 1'b1);
    chk("rd_rdata", u_if.HOST_RDATA, 9'h0AB);

    // scan fetch on line 0
    for (int h = 0; h < 26; h++) begin
      next_cycle(); set_pos(h, 0);
      @(negedge clk);
      if (h == 4) begin
        chk("scan_addr4", mem_addr, 15'h0001);
        chk("scan_we4", mem_we, 1'b0);
        chk("scan_ready4", u_if.HOST_READY, 1'b0);
      end
      if (h >= 6 && h <= 9) chk("scan_red_px", {red, green, blue}, 9'h1C0);
      if (h == 10) chk("scan_next_grp", {red, green, blue}, 9'h000);
      if (h == 22) chk("scan_white", {red, green, blue}, 9'h1FF);
    end

    // contention: host writes held for a whole active line
    host_drv(1'b1, 1'b1, 15'h3000, 9'h155);
    acc = 0;
    stall = 0;
    for (int h = 0; h < 640; h++) begin
      next_cycle(); set_pos(h, 4);
      @(negedge clk);
      if (u_if.HOST_READY) acc++;
      else stall++;
    end
    chk("line_accepts", acc, 480);
    chk("line_stalls", stall, 160);

    // horizontal blanking and sync region on a vsync line
    host_drv(1'b0, 1'b0, 0, 0);
    for (int h = 640; h < 800; h++) begin
      next_cycle(); set_pos(h, 490);
      @(negedge clk);
      if (h == 660) begin
        chk("hsync_low", vga_hs, 1'b0);
        chk("vsync_low", vga_vs, 1'b0);
      end
    end

    // frame wrap with a held host read
    host_drv(1'b1, 1'b0, 1, 0);
    next_cycle(); set_pos(799, 524);
    for (int h = 0; h < 8; h++) begin
      next_cycle(); set_pos(h, 0);
    end

    // reset while a read is in flight
    next_cycle(); set_pos(20, 500); host_drv(1'b1, 1'b0, 5, 0);
    @(negedge clk);
    chk("rr_accept", u_if.HOST_READY, 1'b1);
    next_cycle(); rst = 1'b1; set_pos(21, 500); host_drv(1'b0, 1'b0, 0, 0);
    @(negedge clk);
    chk("rr_rvalid_rst", u_if.HOST_RVALID, 1'b0);
    chk("rr_ready_rst", u_if.HOST_READY, 1'b0);
    chk("rr_we_rst", mem_we, 1'b0);
    next_cycle(); rst = 1'b0; set_pos(22, 500);
    @(negedge clk);
    chk("rr_rvalid_after", u_if.HOST_RVALID, 1'b0);
    chk("rr_rgb_after", {red, green, blue}, 9'h000);
    chk("rr_hsync_after", vga_hs, 1'b1);
    chk("rr_vsync_after", vga_vs, 1'b1);

    for (int i = 0; i < 4; i++) begin
      next_cycle(); set_pos(23 + i, 500);
    end
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
